uart_rx: RTL

- UART receiver that de-serialises the serial line driven by the team's UART transmitter and presents whole bytes to downstream logic.
- Frame format: 8N1, with optional odd or even parity. Data is LSB first.
- Sits directly downstream of the transmitter, either at the FPGA pin or in a loopback. Outputs one byte per frame with a single-cycle valid strobe and an error strobe.

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 96 +++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and received-byte outputs of the UART receiver
interface uart_rx_if;
    logic       rx_din;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;
    modport master (input rx_din, output rx_data, rx_done, rx_err, rx_busy);
    modport slave  (output rx_din, input rx_data, rx_done, rx_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with optional odd/even parity, mid-bit sampling
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int PARITY   = 0
) (
    input logic       sys_clk,
    input logic       sys_rst_n,
    uart_rx_if.master bus
);
    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int          HALF     = BPS_CNT / 2;
    localparam logic [15:0] BIT_END  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam bit          HAS_PAR  = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_rx_s, r_rx_s_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift, r_data;
    logic        r_par_err, r_done, r_err;
    logic        w_fall, w_tick, w_half, w_exp_par;

    assign w_fall    = r_rx_s_d & ~r_rx_s;
    assign w_tick    = r_cnt == BIT_END;
    assign w_half    = r_cnt == HALF_END;
    assign w_exp_par = (PARITY == 1) ? ~^r_shift : ^r_shift;

    assign bus.rx_data = r_data;
    assign bus.rx_done = r_done;
    assign bus.rx_err  = r_err;
    assign bus.rx_busy = r_state != IDLE;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: a start edge that is not still low at half-bit is a glitch
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_half) w_next = r_rx_s ? IDLE : DATA;
            DATA:    if (w_tick && r_bit == 3'd7) w_next = HAS_PAR ? PAR : STOP;
            PAR:     if (w_tick) w_next = STOP;
            STOP:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Synchroniser, bit timing, shift register and one-cycle result strobes
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync1  <= bus.rx_din;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
            r_cnt    <= (w_next != r_state || w_tick) ? '0 : r_cnt + 16'd1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            if (r_state == START) begin
                r_bit     <= '0;
                r_par_err <= 1'b0;
            end
            if (r_state == DATA && w_tick) begin
                r_shift[r_bit] <= r_rx_s;
                r_bit          <= r_bit + 3'd1;
            end
            if (r_state == PAR && w_tick)
                r_par_err <= r_rx_s != w_exp_par;
            if (r_state == STOP && w_tick) begin
                r_done <= r_rx_s & ~r_par_err;
                r_err  <= ~r_rx_s | r_par_err;
                if (r_rx_s && !r_par_err)
                    r_data <= r_shift;
            end
        end
    end
endmodule
